dual_issue_fetch_queue: RTL

DUAL_ISSUE_FETCH_QUEUE -- requirements
Module: dual_issue_fetch_queue

---
 rtl/dual_issue_fetch_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/dual_issue_fetch_queue.sv
// dual_issue_fetch_queue: circular instruction queue presenting the two oldest entries to the PE1/PE2 decode lanes.
// Optional macro DUAL_ISSUE_EN enables pairing; undefined gives a single-issue queue.
`default_nettype none

module dual_issue_fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  input  logic                     flush,
  input  logic                     issue_ready,
  output logic                     lane1_valid,
  output logic [31:0]              lane1_instr,
  output logic [31:0]              lane1_pc,
  output logic                     lane2_valid,
  output logic [31:0]              lane2_instr,
  output logic [31:0]              lane2_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic [1:0]    pop_num;

  assign rd_ptr_nxt  = rd_ptr_q + AW'(1);
  assign in_ready    = (count_q < (AW+1)'(DEPTH));
  assign push        = in_valid && in_ready && !flush;
  assign lane1_valid = (count_q != '0);
  assign lane1_instr = instr_mem_q[rd_ptr_q];
  assign lane1_pc    = pc_mem_q[rd_ptr_q];
  assign lane2_instr = instr_mem_q[rd_ptr_nxt];
  assign lane2_pc    = pc_mem_q[rd_ptr_nxt];
  assign count       = count_q;

`ifdef DUAL_ISSUE_EN
  logic [6:0] op1, op2;
  logic [4:0] rd1;
  logic       mem1, mem2, wr1, uses_rs2_2, raw, hazard;

  assign op1        = lane1_instr[6:0];
  assign op2        = lane2_instr[6:0];
  assign rd1        = lane1_instr[11:7];
  assign mem1       = (op1 == 7'b0000011) || (op1 == 7'b0100011);
  assign mem2       = (op2 == 7'b0000011) || (op2 == 7'b0100011);
  assign wr1        = (op1 == 7'b0000011) || (op1 == 7'b0110011) || (op1 == 7'b0010011);
  assign uses_rs2_2 = (op2 == 7'b0110011) || (op2 == 7'b0100011) || (op2 == 7'b1100011);
  // rs2 field of I-type/load lane2 is immediate bits, so it only counts for R/S/B formats
  assign raw        = wr1 && (rd1 != 5'd0) &&
                      ((rd1 == lane2_instr[19:15]) || (uses_rs2_2 && (rd1 == lane2_instr[24:20])));
  assign hazard     = (op1 == 7'b1100011) || (mem1 && mem2) || raw;
  assign lane2_valid = lane1_valid && (count_q >= (AW+1)'(2)) && !hazard;
`else
  assign lane2_valid = 1'b0;
`endif

  always_comb begin
    pop_num = 2'd0;
    if (issue_ready) begin
      if (lane2_valid) begin
        pop_num = 2'd2;
      end else if (lane1_valid) begin
        pop_num = 2'd1;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop_num);
      wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop_num);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

endmodule

`default_nettype wire
